elevator_ctrl: RTL and testbench
================================

// Module: elevator_ctrl
// PURPOSE
//  Single-car elevator controller: latches floor requests into a pending set
//  and serves them SCAN-style, continuing in one direction while requests
//  remain ahead. It moves one floor per FLOOR_CYCLES clocks and opens the
//  door for DOOR_CYCLES clocks at each served floor.
//  Top-level car-control block, fed by the floor-button decoder.
// PARAMETERS
//  NUM_FLOORS   32  floors 0..NUM_FLOORS-1 (max 32, floor ids are 5-bit)
//  FLOOR_CYCLES 2   clocks of travel per floor (>=1)
//  DOOR_CYCLES  3   clocks door stays open (>=1)
// PORTS
//  clk        in   1  single clock; all state updates on rising edge
//  reset      in   1  asynchronous, active-low reset (0 = in reset)
//  r_f        in   5  requested floor, binary floor number
//  t_f        out  5  current target floor (registered)
//  state_out  out  3  FSM state code
//  door       out  1  1 = door open
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, c_f=0, t_f=0, door=0, pending=0,
//   dir=UP, timers=0, r_prev=0. Held until reset returns high. Reset mid-move
//   or mid-door aborts immediately to these values.
//  Internal c_f[4:0] = current floor; bench hierarchically reads dut.c_f.
//  Request capture: each edge, if r_f != r_prev and r_f < NUM_FLOORS, set
//   pending[r_f]; r_prev<=r_f. Held value = one request; out-of-range ignored.
//   A request for floor 0 directly after reset needs r_f to change first.
//  state_out: IDLE=000, MOVE_UP=001, MOVE_DOWN=010, DOOR_OPEN=011,
//   DOOR_CLOSE=100; codes 101-111 unused -> recover to IDLE.
//  door = 1 exactly while state==DOOR_OPEN (registered with state).
//  IDLE: pending[c_f] -> DOOR_OPEN, clear bit. Else requests above and
//   (dir==UP or none below) -> MOVE_UP, dir=UP; else requests below ->
//   MOVE_DOWN, dir=DOWN; else stay. t_f <= nearest pending floor in chosen dir.
//  MOVE_UP/DOWN: timer counts 0..FLOOR_CYCLES-1; at FLOOR_CYCLES-1 c_f+/-1,
//   timer=0. If the new floor is pending -> DOOR_OPEN, clear bit, door=1.
//   t_f updates each edge to nearest pending floor ahead (new requests that
//   lie between c_f and t_f are served en route).
//  DOOR_OPEN: hold DOOR_CYCLES clocks then DOOR_CLOSE. New request for c_f
//   during DOOR_OPEN restarts door timer and is not left pending.
//  DOOR_CLOSE: 1 clock, door=0; then apply IDLE decision rules (no pass
//   through IDLE when work remains; reverse dir only if nothing ahead).
//  c_f never below 0 or above NUM_FLOORS-1 (no wrap-around).
//  Same-edge capture and clear of one floor: capture wins, except c_f in
//   DOOR_OPEN (timer restart as above).
//  t_f holds last value when pending is empty.
// TESTING
//  T1 reset low 2 clks, high; r_f=1 captured edge E0 -> E1 MOVE_UP (001),
//     t_f=1; E3 c_f=1, DOOR_OPEN, door=1; E6 DOOR_CLOSE door=0; E7 IDLE.
//  T2 from floor 1 idle, r_f 1->2 -> MOVE_UP, c_f=2 after 2 clks, door 3 clks.
//  T3 at floor 0, r_f=1 then r_f=3 during travel -> door opens at 1, then at
//     3, no reversal; pending empty, IDLE, t_f=3.
//  T4 at floor 3, pending {1,5} with dir=UP -> serves 5 first then 1 (MOVE_DOWN).
//  T5 r_f=5'd31 with NUM_FLOORS=8 -> ignored, stays IDLE, door=0.
//  T6 reset low during MOVE_UP -> state=000, c_f=0, door=0, pending cleared.

Source files
------------

// File: rtl/elevator_ctrl.sv
// Single-car SCAN elevator controller: latches floor requests into a pending
// set, travels one floor per FLOOR_CYCLES clocks and opens the door at each served floor.
module elevator_ctrl #(
  parameter int NUM_FLOORS   = 32,
  parameter int FLOOR_CYCLES = 2,
  parameter int DOOR_CYCLES  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] r_f,
  output logic [4:0] t_f,
  output logic [2:0] state_out,
  output logic       door
);

  localparam logic [2:0] ST_IDLE       = 3'b000;
  localparam logic [2:0] ST_MOVE_UP    = 3'b001;
  localparam logic [2:0] ST_MOVE_DOWN  = 3'b010;
  localparam logic [2:0] ST_DOOR_OPEN  = 3'b011;
  localparam logic [2:0] ST_DOOR_CLOSE = 3'b100;

  localparam logic [15:0] FLOOR_LAST = 16'(FLOOR_CYCLES - 1);
  localparam logic [15:0] DOOR_LAST  = 16'(DOOR_CYCLES - 1);
  localparam logic [4:0]  TOP_FLOOR  = 5'(NUM_FLOORS - 1);

  logic [2:0]  state, state_n;
  logic [4:0]  c_f, c_f_n, t_f_n, r_prev;
  logic [4:0]  next_up, next_dn;
  logic        dir, dir_n;
  logic [15:0] timer, timer_n;
  logic [31:0] pending, set_mask, clr_mask;
  logic        capture, door_hit;
  logic        above_any, below_any, above_far_any, below_far_any;
  logic [4:0]  above_near, below_near;

  // Nearest pending floor on each side of the car, plus whether anything lies
  // beyond the adjacent floor (decides whether travel continues after arrival).
  always_comb begin
    above_any     = 1'b0;
    below_any     = 1'b0;
    above_far_any = 1'b0;
    below_far_any = 1'b0;
    above_near    = c_f;
    below_near    = c_f;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (i > int'(c_f))) begin
        above_any  = 1'b1;
        above_near = 5'(i);
      end
      if (pending[i] && (i > int'(c_f) + 1)) above_far_any = 1'b1;
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (i < int'(c_f))) begin
        below_any  = 1'b1;
        below_near = 5'(i);
      end
      if (pending[i] && (i < int'(c_f) - 1)) below_far_any = 1'b1;
    end
  end

  // A changed, in-range r_f is one request; a repeat call for the open floor
  // only keeps the door open instead of becoming pending.
  always_comb begin
    capture  = (r_f != r_prev) && (int'(r_f) < NUM_FLOORS);
    door_hit = capture && (state == ST_DOOR_OPEN) && (r_f == c_f);
    set_mask = '0;
    if (capture && !door_hit) set_mask[r_f] = 1'b1;
  end

  always_comb begin
    state_n  = state;
    c_f_n    = c_f;
    t_f_n    = t_f;
    dir_n    = dir;
    timer_n  = timer;
    clr_mask = '0;
    next_up  = c_f + 5'd1;
    next_dn  = c_f - 5'd1;
    case (state)
      ST_IDLE, ST_DOOR_CLOSE: begin
        timer_n = '0;
        if (pending[c_f]) begin
          state_n       = ST_DOOR_OPEN;
          clr_mask[c_f] = 1'b1;
          t_f_n         = c_f;
        end else if (above_any && (dir || !below_any)) begin
          state_n = ST_MOVE_UP;
          dir_n   = 1'b1;
          t_f_n   = above_near;
        end else if (below_any) begin
          state_n = ST_MOVE_DOWN;
          dir_n   = 1'b0;
          t_f_n   = below_near;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_MOVE_UP: begin
        if (above_any) t_f_n = above_near;
        if (timer == FLOOR_LAST) begin
          timer_n = '0;
          if (c_f < TOP_FLOOR) begin
            c_f_n = next_up;
            if (pending[next_up]) begin
              state_n           = ST_DOOR_OPEN;
              clr_mask[next_up] = 1'b1;
            end else if (!above_far_any) begin
              state_n = ST_IDLE;
            end
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          timer_n = timer + 16'd1;
        end
      end
      ST_MOVE_DOWN: begin
        if (below_any) t_f_n = below_near;
        if (timer == FLOOR_LAST) begin
          timer_n = '0;
          if (c_f > 5'd0) begin
            c_f_n = next_dn;
            if (pending[next_dn]) begin
              state_n           = ST_DOOR_OPEN;
              clr_mask[next_dn] = 1'b1;
            end else if (!below_far_any) begin
              state_n = ST_IDLE;
            end
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          timer_n = timer + 16'd1;
        end
      end
      ST_DOOR_OPEN: begin
        if (door_hit) begin
          timer_n = '0;
        end else if (timer == DOOR_LAST) begin
          state_n = ST_DOOR_CLOSE;
          timer_n = '0;
        end else begin
          timer_n = timer + 16'd1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        timer_n = '0;
      end
    endcase
  end

  // Capture wins over a same-edge clear so a fresh call is never lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      c_f     <= '0;
      t_f     <= '0;
      dir     <= 1'b1;
      timer   <= '0;
      pending <= '0;
      r_prev  <= '0;
      door    <= 1'b0;
    end else begin
      state   <= state_n;
      c_f     <= c_f_n;
      t_f     <= t_f_n;
      dir     <= dir_n;
      timer   <= timer_n;
      pending <= (pending & ~clr_mask) | set_mask;
      r_prev  <= r_f;
      door    <= (state_n == ST_DOOR_OPEN);
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl: directed scenarios plus random request traffic,
// all checked every cycle against a floor-list reference model.
module tb_elevator_ctrl;

  localparam int NF = 8;
  localparam int FC = 2;
  localparam int DC = 3;

  localparam int S_IDLE  = 0;
  localparam int S_UP    = 1;
  localparam int S_DOWN  = 2;
  localparam int S_OPEN  = 3;
  localparam int S_CLOSE = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] r_f   = '0;
  logic [4:0] t_f;
  logic [2:0] state_out;
  logic       door;

  elevator_ctrl #(
    .NUM_FLOORS  (NF),
    .FLOOR_CYCLES(FC),
    .DOOR_CYCLES (DC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .r_f      (r_f),
    .t_f      (t_f),
    .state_out(state_out),
    .door     (door)
  );

  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;

  int mState, mCf, mTf, mRprev, mTravel, mDoorLeft;
  bit mUp;
  bit mPend[NF];

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nCompared++;
    if (observed != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll(input string ctx);
    checkOutput({ctx, " state"}, int'(state_out), mState);
    checkOutput({ctx, " t_f"}, int'(t_f), mTf);
    checkOutput({ctx, " door"}, int'(door), (mState == S_OPEN) ? 1 : 0);
    checkOutput({ctx, " c_f"}, int'(dut.c_f), mCf);
  endtask

  function automatic int nearestAbove(input int from);
    for (int f = from + 1; f < NF; f++) if (mPend[f]) return f;
    return -1;
  endfunction

  function automatic int nearestBelow(input int from);
    for (int f = from - 1; f >= 0; f--) if (mPend[f]) return f;
    return -1;
  endfunction

  task automatic modelReset();
    mState = S_IDLE; mCf = 0; mTf = 0; mRprev = 0;
    mTravel = 0; mDoorLeft = 0; mUp = 1'b1;
    for (int f = 0; f < NF; f++) mPend[f] = 1'b0;
  endtask

  // One rising edge of the car, computed from the pre-edge picture.
  task automatic modelStep(input int rf);
    int nState, nCf, nTf, nTravel, nDoorLeft, served, up, dn;
    bit nUp, cap, hit;
    nState = mState; nCf = mCf; nTf = mTf; nTravel = mTravel;
    nDoorLeft = mDoorLeft; nUp = mUp; served = -1;
    cap = (rf != mRprev) && (rf < NF);
    hit = cap && (mState == S_OPEN) && (rf == mCf);
    up = nearestAbove(mCf);
    dn = nearestBelow(mCf);
    case (mState)
      S_IDLE, S_CLOSE: begin
        if (mPend[mCf]) begin
          nState = S_OPEN; served = mCf; nTf = mCf; nDoorLeft = DC;
        end else if (up >= 0 && (mUp || dn < 0)) begin
          nState = S_UP; nUp = 1'b1; nTf = up; nTravel = FC;
        end else if (dn >= 0) begin
          nState = S_DOWN; nUp = 1'b0; nTf = dn; nTravel = FC;
        end else begin
          nState = S_IDLE;
        end
      end
      S_UP: begin
        if (up >= 0) nTf = up;
        nTravel = mTravel - 1;
        if (nTravel == 0) begin
          nTravel = FC;
          if (mCf < NF - 1) begin
            nCf = mCf + 1;
            if (mPend[nCf]) begin
              nState = S_OPEN; served = nCf; nDoorLeft = DC;
            end else if (nearestAbove(nCf) < 0) begin
              nState = S_IDLE;
            end
          end else begin
            nState = S_IDLE;
          end
        end
      end
      S_DOWN: begin
        if (dn >= 0) nTf = dn;
        nTravel = mTravel - 1;
        if (nTravel == 0) begin
          nTravel = FC;
          if (mCf > 0) begin
            nCf = mCf - 1;
            if (mPend[nCf]) begin
              nState = S_OPEN; served = nCf; nDoorLeft = DC;
            end else if (nearestBelow(nCf) < 0) begin
              nState = S_IDLE;
            end
          end else begin
            nState = S_IDLE;
          end
        end
      end
      S_OPEN: begin
        if (hit) nDoorLeft = DC;
        else begin
          nDoorLeft = mDoorLeft - 1;
          if (nDoorLeft == 0) nState = S_CLOSE;
        end
      end
      default: nState = S_IDLE;
    endcase
    if (served >= 0) mPend[served] = 1'b0;
    if (cap && !hit) mPend[rf] = 1'b1;
    mState = nState; mCf = nCf; mTf = nTf; mUp = nUp;
    mTravel = nTravel; mDoorLeft = nDoorLeft; mRprev = rf;
  endtask

  task automatic applyStimulus(input int rf, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      r_f = 5'(rf);
      @(posedge clk);
      modelStep(rf);
      #1;
      checkAll("model");
    end
  endtask

  // Asynchronous reset asserted between edges, held two clocks.
  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    r_f   = '0;
    #1;
    modelReset();
    checkAll("async reset");
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset hold");
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int cur;
    int p;
    doReset();
    checkOutput("T1 reset state", int'(state_out), S_IDLE);
    checkOutput("T1 reset door", int'(door), 0);

    applyStimulus(1, 1);
    checkOutput("T1 E0 state", int'(state_out), S_IDLE);
    applyStimulus(1, 1);
    checkOutput("T1 E1 state", int'(state_out), S_UP);
    checkOutput("T1 E1 t_f", int'(t_f), 1);
    applyStimulus(1, 2);
    checkOutput("T1 E3 state", int'(state_out), S_OPEN);
    checkOutput("T1 E3 door", int'(door), 1);
    checkOutput("T1 E3 c_f", int'(dut.c_f), 1);
    applyStimulus(1, 3);
    checkOutput("T1 E6 state", int'(state_out), S_CLOSE);
    checkOutput("T1 E6 door", int'(door), 0);
    applyStimulus(1, 1);
    checkOutput("T1 E7 state", int'(state_out), S_IDLE);

    applyStimulus(2, 2);
    checkOutput("T2 moving", int'(state_out), S_UP);
    applyStimulus(2, 2);
    checkOutput("T2 c_f", int'(dut.c_f), 2);
    checkOutput("T2 door", int'(door), 1);
    applyStimulus(2, 2);
    checkOutput("T2 door held", int'(door), 1);
    applyStimulus(2, 1);
    checkOutput("T2 door closed", int'(door), 0);

    applyStimulus(0, 14);
    checkOutput("T3 start floor", int'(dut.c_f), 0);
    applyStimulus(1, 1);
    applyStimulus(3, 22);
    checkOutput("T3 state", int'(state_out), S_IDLE);
    checkOutput("T3 c_f", int'(dut.c_f), 3);
    checkOutput("T3 t_f", int'(t_f), 3);

    applyStimulus(4, 4);
    checkOutput("T4 door at 4", int'(state_out), S_OPEN);
    checkOutput("T4 c_f 4", int'(dut.c_f), 4);
    applyStimulus(1, 1);
    applyStimulus(6, 2);
    checkOutput("T4 close", int'(state_out), S_CLOSE);
    applyStimulus(6, 1);
    checkOutput("T4 keeps up", int'(state_out), S_UP);
    checkOutput("T4 target 6", int'(t_f), 6);
    applyStimulus(6, 40);
    checkOutput("T4 end c_f", int'(dut.c_f), 1);
    checkOutput("T4 end state", int'(state_out), S_IDLE);

    applyStimulus(31, 5);
    checkOutput("T5 state", int'(state_out), S_IDLE);
    checkOutput("T5 door", int'(door), 0);

    applyStimulus(7, 3);
    checkOutput("T6 moving", int'(state_out), S_UP);
    doReset();
    checkOutput("T6 state", int'(state_out), S_IDLE);
    checkOutput("T6 c_f", int'(dut.c_f), 0);
    checkOutput("T6 door", int'(door), 0);
    applyStimulus(0, 5);
    checkOutput("T6 pending cleared", int'(state_out), S_IDLE);

    cur = 0;
    for (int n = 0; n < 3000; n++) begin
      p = int'($urandom_range(0, 199));
      if (p == 0) doReset();
      else if (p < 50) cur = int'($urandom_range(0, NF + 1));
      else if (p < 54) cur = 31;
      applyStimulus(cur, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
